// File: rtl/alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler
//   Shares one external ALU between two requesters. A round-robin arbiter
//   picks one command at a time, the operands and control are registered onto
//   the ALU inputs, the scheduler waits the op-dependent settle time, then
//   captures the ALU result into a response buffer held until accepted.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid[1:0]    per-requester command valid
//   o_req_ready[1:0]    per-requester accept (combinational, IDLE only)
//   i_req_op[1:0][2:0]  opcode: 000 add, 001 sub, 010 mul, 011 shr, 100 shl
//   i_req_one[1:0]      replace b with 1 (inc/dec)
//   i_req_a/i_req_b     per-requester operands
//   o_alu_a/o_alu_b     registered ALU operands
//   o_alu_control[3:0]  {op, one}
//   i_alu_r             ALU result
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_id            requester that issued the command
//   o_rsp_data          captured ALU result (0 on illegal op)
//   o_rsp_err           illegal opcode flag
// ---------------------------------------------------------------------------
module alu_req_scheduler #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2,
  parameter int ALU_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [1:0][2:0]       i_req_op,
  input  logic [1:0]            i_req_one,
  input  logic [1:0][WIDTH-1:0] i_req_a,
  input  logic [1:0][WIDTH-1:0] i_req_b,
  output logic [WIDTH-1:0]      o_alu_a,
  output logic [WIDTH-1:0]      o_alu_b,
  output logic [3:0]            o_alu_control,
  input  logic [WIDTH-1:0]      i_alu_r,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_id,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic                  o_rsp_err
);

  localparam int CNT_MAX = (MUL_CYCLES > ALU_CYCLES) ? MUL_CYCLES : ALU_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MAX = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic             r_last_id;   // requester granted most recently
  logic             r_fresh;     // no grant since reset: requester 0 wins a tie
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [3:0]       r_alu_ctl;
  logic             r_rsp_valid, r_rsp_id, r_rsp_err;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_grant_id;
  logic [2:0]       w_sel_op;
  logic             w_sel_illegal;
  logic [CW-1:0]    w_cnt_load;
  logic             w_accept;

  // Arbitration: a tie goes to whoever was not granted last time.
  always_comb begin
    w_grant_id = 1'b0;
    case (i_req_valid)
      2'b11:   w_grant_id = r_fresh ? 1'b0 : ~r_last_id;
      2'b10:   w_grant_id = 1'b1;
      default: w_grant_id = 1'b0;
    endcase
    w_sel_op      = i_req_op[w_grant_id];
    w_sel_illegal = (w_sel_op > OP_MAX);
    w_cnt_load    = (w_sel_op == OP_MUL) ? CW'(MUL_CYCLES) : CW'(ALU_CYCLES);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 2'b00;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req_valid) begin
          o_req_ready = 2'b01 << w_grant_id;
          w_accept    = 1'b1;
          // Illegal ops skip the ALU entirely and answer immediately.
          w_state_nxt = w_sel_illegal ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_id   <= 1'b0;
      r_fresh     <= 1'b1;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctl   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_id <= w_grant_id;
            r_fresh   <= 1'b0;
            r_rsp_id  <= w_grant_id;
            if (w_sel_illegal) begin
              // ALU inputs are left untouched so it sees no activity.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              r_alu_a   <= i_req_a[w_grant_id];
              r_alu_b   <= i_req_b[w_grant_id];
              r_alu_ctl <= {w_sel_op, i_req_one[w_grant_id]};
              r_cnt     <= w_cnt_load;
            end
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CW'(1);
          // Counter hitting 1 means alu_r has had its full settle time.
          if (r_cnt == CW'(1)) begin
            r_rsp_data  <= i_alu_r;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_control = r_alu_ctl;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_err     = r_rsp_err;

endmodule
